systolic_edge_feeder: RTL and testbench

Transmit side of the processing-element grid interface. It stores an A operand matrix (N rows x K) and a B operand matrix (K x N), then streams them into the west and north edges of an N x N PE array. Row i and column j are skewed by i and j cycles so that matching operands meet in each PE. It also issues an accumulator-clear pulse before streaming and signals completion once the last products have propagated to the far corner.

---
 rtl/systolic_edge_feeder.sv | 153 +++++++++++++++
 tb/tb_systolic_edge_feeder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder
//   Holds an A operand matrix (N x K) and a B operand matrix (K x N) and
//   streams them into the west / north edges of an N x N PE array. Row i and
//   column j are delayed by i and j cycles so matching operands meet in
//   each PE. Sequence per transfer: CLEAR (pe_clr) -> FEED (K+N-1 cycles)
//   -> DRAIN (N-1 cycles) -> DONE (done pulse).
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   wr_en/wr_sel     buffer write strobe, 0 = A, 1 = B (accepted only in IDLE)
//   wr_row/wr_col    element index; out-of-range writes are dropped
//   wr_data          element value
//   k_len, start     inner dimension (clamped to KMAX) and transfer request
//   a_edge, b_edge   per-lane operands, lane i at [i*DATA_W +: DATA_W]
//   feed_valid       high during FEED
//   pe_clr           one-cycle accumulator clear ahead of FEED
//   busy, done       not-IDLE flag, one-cycle completion pulse
// All outputs are registered.
module systolic_edge_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int KMAX   = 8,
  parameter int IDX_W  = $clog2((N > KMAX) ? N : KMAX),
  parameter int KW     = $clog2(KMAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [IDX_W-1:0]    wr_row,
  input  logic [IDX_W-1:0]    wr_col,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [KW-1:0]       k_len,
  input  logic                start,
  output logic [N*DATA_W-1:0] a_edge,
  output logic [N*DATA_W-1:0] b_edge,
  output logic                feed_valid,
  output logic                pe_clr,
  output logic                busy,
  output logic                done
);

  // counter must reach KMAX+2N without wrapping
  localparam int CW = $clog2(KMAX + 2*N + 1);
  localparam int NI = (N > 1) ? $clog2(N) : 1;
  localparam int KI = (KMAX > 1) ? $clog2(KMAX) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [KW-1:0]   k_q, k_nxt, k_clamp;
  logic [CW-1:0]   feed_end;

  logic [DATA_W-1:0] a_mem [N][KMAX];
  logic [DATA_W-1:0] b_mem [KMAX][N];

  logic [N-1:0][DATA_W-1:0] a_nxt, b_nxt;

  // ---------------------------------------------------------------- buffers
  // Not reset: contents survive reset. Write lands on the same edge that
  // accepts a start, so it is visible to the transfer (first read is a cycle
  // later, when FEED t=0 is registered).
  logic wr_ok, a_wr, b_wr;
  assign wr_ok = wr_en && (state == IDLE);
  assign a_wr  = wr_ok && !wr_sel && (int'(wr_row) < N)    && (int'(wr_col) < KMAX);
  assign b_wr  = wr_ok &&  wr_sel && (int'(wr_row) < KMAX) && (int'(wr_col) < N);

  always_ff @(posedge clk) begin
    if (a_wr) a_mem[wr_row[NI-1:0]][wr_col[KI-1:0]] <= wr_data;
    if (b_wr) b_mem[wr_row[KI-1:0]][wr_col[NI-1:0]] <= wr_data;
  end

  // ---------------------------------------------------------------- FSM
  assign k_clamp  = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  // last FEED index is K+N-2; K >= 1 whenever FEED is entered
  assign feed_end = CW'(k_q) + CW'(N - 1) - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      k_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      k_q   <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    k_nxt     = k_q;
    case (state)
      IDLE: if (start) begin
        k_nxt     = k_clamp;
        cnt_nxt   = '0;
        state_nxt = (k_clamp == '0) ? DONE : CLEAR;
      end
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = FEED;
      end
      FEED: if (cnt == feed_end) begin
        cnt_nxt   = '0;
        state_nxt = (N > 1) ? DRAIN : DONE;
      end else begin
        cnt_nxt   = cnt + CW'(1);
      end
      DRAIN: if (cnt == CW'(N - 2)) begin
        cnt_nxt   = '0;
        state_nxt = DONE;
      end else begin
        cnt_nxt   = cnt + CW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- edges
  // Edges are computed from the next state/counter so the registered output
  // lines up with the cycle the FSM is in. Lane g carries element index
  // t-g; outside 0..K-1 it is forced to zero since PEs accumulate every cycle.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [CW-1:0] kk;
    logic          ok;
    assign kk       = cnt_nxt - CW'(g);
    assign ok       = (state_nxt == FEED) && (cnt_nxt >= CW'(g)) && (kk < CW'(k_q));
    assign a_nxt[g] = ok ? a_mem[g][kk[KI-1:0]] : '0;
    assign b_nxt[g] = ok ? b_mem[kk[KI-1:0]][g] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_edge     <= '0;
      b_edge     <= '0;
      feed_valid <= 1'b0;
      pe_clr     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      a_edge     <= a_nxt;
      b_edge     <= b_nxt;
      feed_valid <= (state_nxt == FEED);
      pe_clr     <= (state_nxt == CLEAR);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Scoreboard bench for systolic_edge_feeder: each transfer pushes its
// per-cycle expected outputs at start, pops one entry per cycle. A small
// PE-grid model driven by the DUT edges checks C = A*B mod 256.
module tb_systolic_edge_feeder;
  localparam int N = 4, DW = 8, KMAX = 8;
  localparam int IDX_W = 3, KW = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [IDX_W-1:0] wr_row = '0, wr_col = '0;
  logic [DW-1:0] wr_data = '0;
  logic [KW-1:0] k_len = '0;
  logic [N*DW-1:0] a_edge, b_edge;
  logic feed_valid, pe_clr, busy, done;

  systolic_edge_feeder #(.N(N), .DATA_W(DW), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .k_len(k_len), .start(start),
    .a_edge(a_edge), .b_edge(b_edge), .feed_valid(feed_valid), .pe_clr(pe_clr),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [N*DW-1:0] a, b;
    logic fv, clr, bz, dn;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0, n_err = 0;
  int ma [N][KMAX];
  int mb [KMAX][N];

  // PE grid model
  logic [DW-1:0] pa [N][N], pb [N][N], acc [N][N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      pa[i][0] <= a_edge[i*DW +: DW];
      pb[0][i] <= b_edge[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        pa[i][j] <= pa[i][j-1];
        pb[j][i] <= pb[j-1][i];
      end
      for (int j = 0; j < N; j++)
        acc[i][j] <= pe_clr ? '0 : DW'(acc[i][j] + DW'(pa[i][j] * pb[i][j]));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit sel, input int row, input int col, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_row = IDX_W'(row); wr_col = IDX_W'(col);
    wr_data = DW'(data);
    if (!sel && row < N && col < KMAX) ma[row][col] = data;
    if (sel && row < KMAX && col < N) mb[row][col] = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".a"}, a_edge, '0);
    chk({tag, ".b"}, b_edge, '0);
    chk({tag, ".fv"}, feed_valid, 0);
    chk({tag, ".clr"}, pe_clr, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  // kl: k_len; inj_t: FEED t at which a write+start are attempted (-1 none);
  // rst_t: FEED t at which reset is raised (-1 none); same_wr: write A[0][0]
  // in the start cycle.
  task automatic go(input int kl, input int inj_t, input int rst_t, input bit same_wr);
    int K, L, c, t, s;
    bit rst_hit;
    exp_t e;
    K = (kl > KMAX) ? KMAX : kl;
    rst_hit = 0;
    if (same_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'h77;
      ma[0][0] = 'h77;
    end
    L = (K == 0) ? 1 : K + 2*N;
    for (int cc = 1; cc <= L; cc++) begin
      e.a = '0; e.b = '0; e.fv = 0; e.clr = 0; e.bz = 1; e.dn = (cc == L);
      if (K > 0 && cc == 1) e.clr = 1;
      if (K > 0 && cc >= 2 && cc <= K + N) begin
        e.fv = 1;
        for (int i = 0; i < N; i++) begin
          int k = cc - 2 - i;
          if (k >= 0 && k < K) begin
            e.a[i*DW +: DW] = DW'(ma[i][k]);
            e.b[i*DW +: DW] = DW'(mb[k][i]);
          end
        end
      end
      exp_q.push_back(e);
    end
    start = 1'b1; k_len = KW'(kl);
    c = 0;
    while (exp_q.size() > 0) begin
      tick(); c++;
      start = 1'b0; wr_en = 1'b0; rst = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("c%0d.a", c), a_edge, e.a);
      chk($sformatf("c%0d.b", c), b_edge, e.b);
      chk($sformatf("c%0d.fv", c), feed_valid, e.fv);
      chk($sformatf("c%0d.clr", c), pe_clr, e.clr);
      chk($sformatf("c%0d.busy", c), busy, e.bz);
      chk($sformatf("c%0d.done", c), done, e.dn);
      t = c - 2;
      if (K > 0 && t == inj_t) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'hEE;
        start = 1'b1; k_len = KW'(2);
      end
      if (K > 0 && t == rst_t) begin
        rst = 1'b1; rst_hit = 1; exp_q.delete();
      end
    end
    tick();
    start = 1'b0; wr_en = 1'b0; rst = 1'b0;
    chk_idle("post");
    if (!rst_hit && K > 0)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          s = 0;
          for (int k = 0; k < K; k++) s += ma[i][k] * mb[k][j];
          chk($sformatf("C%0d%0d", i, j), acc[i][j], s & 255);
        end
    for (int x = 0; x < 3; x++) begin
      tick();
      chk("quiet.done", done, 0);
      chk("quiet.busy", busy, 0);
    end
  endtask

  initial begin
    tick(); tick();
    chk_idle("rst");
    rst = 1'b0;
    tick();
    chk_idle("idle");
    // zero-fill, then a single marker element
    for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++) wr(0, i, k, 0);
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) wr(1, k, j, 0);
    wr(0, 1, 2, 'h05);
    go(4, -1, -1, 0);
    // structured matrices
    for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++) wr(0, i, k, 'h10*i + k);
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) wr(1, k, j, 'h10*k + j);
    go(4, -1, -1, 0);
    go(0, -1, -1, 0);           // K=0: straight to DONE
    go(4, 1, -1, 0);            // write+start during FEED ignored
    go(4, -1, -1, 0);           // buffer unchanged
    go(4, -1, 2, 0);            // reset mid-FEED
    go(4, -1, -1, 0);           // fresh start completes
    go(15, -1, -1, 0);          // clamp to KMAX
    // out-of-range writes must not alias into the buffers
    wr(0, 4, 0, 'hAA);
    wr(1, 0, 4, 'hBB);
    wr(1, 0, 5, 'hBC);
    go(4, -1, -1, 1);           // write in start cycle is visible
    // random operands, odd K
    for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++) wr(0, i, k, $urandom_range(255));
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) wr(1, k, j, $urandom_range(255));
    go(5, -1, -1, 0);
    go(1, -1, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
